// File: rtl/branch_predictor.sv
// Direct-mapped bimodal branch predictor with BTB: combinational fetch query,
// combinational resolve/mispredict check, and edge-triggered table update.
module branch_predictor #(
   parameter int ENTRIES = 16,
   parameter int IDX_WID = $clog2(ENTRIES),
   parameter int TAG_WID = 30 - IDX_WID
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] if_pc,
   output logic        predict_taken,
   output logic [31:0] predict_target,
   input  logic        old_branch,
   input  logic [31:0] old_pc,
   input  logic        branch_result,
   input  logic        old_predict,
   input  logic [31:0] ex_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_cnt,
   output logic [31:0] miss_cnt
);

   localparam logic [1:0] CTR_WEAK_NT = 2'b01;
   localparam logic [1:0] CTR_WEAK_T  = 2'b10;

   // Only valid and ctr are reset; tag and target are qualified by valid.
   logic               valid_q  [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [TAG_WID-1:0] tag_q    [ENTRIES];
   logic [31:0]        target_q [ENTRIES];

   logic [IDX_WID-1:0] q_idx;
   logic [TAG_WID-1:0] q_tag;
   logic               q_hit;

   logic [IDX_WID-1:0] u_idx;
   logic [TAG_WID-1:0] u_tag;
   logic               u_hit;
   logic               target_differs;
   logic [1:0]         ctr_next;
   logic               unused_pc_bits;

   assign unused_pc_bits = &{1'b0, if_pc[1:0], old_pc[1:0]};

   // Fetch-side query
   assign q_idx = if_pc[IDX_WID+1:2];
   assign q_tag = if_pc[31:IDX_WID+2];
   assign q_hit = valid_q[q_idx] && (tag_q[q_idx] == q_tag);

   assign predict_taken  = q_hit && ctr_q[q_idx][1];
   assign predict_target = predict_taken ? target_q[q_idx] : (if_pc + 32'd4);

   // Resolve side: an entry that does not hold this branch counts as a wrong target.
   assign u_idx = old_pc[IDX_WID+1:2];
   assign u_tag = old_pc[31:IDX_WID+2];
   assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

   assign target_differs = !u_hit || (target_q[u_idx] != ex_target);

   always_comb begin
      mispredict = 1'b0;
      if (old_branch) begin
         if (branch_result != old_predict)
            mispredict = 1'b1;
         else if (branch_result && old_predict && target_differs)
            mispredict = 1'b1;
      end
   end

   assign redirect_pc = branch_result ? ex_target : (old_pc + 32'd4);

   always_comb begin
      ctr_next = ctr_q[u_idx];
      if (branch_result) begin
         if (ctr_q[u_idx] != 2'b11)
            ctr_next = ctr_q[u_idx] + 2'd1;
      end else begin
         if (ctr_q[u_idx] != 2'b00)
            ctr_next = ctr_q[u_idx] - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            ctr_q[i]   <= CTR_WEAK_NT;
         end
      end else if (old_branch) begin
         if (u_hit) begin
            ctr_q[u_idx] <= ctr_next;
         end else if (branch_result) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= CTR_WEAK_T;
         end
      end
   end

   // Allocation and taken hits both write the target; allocation also writes the tag.
   always_ff @(posedge clk) begin
      if (rst_n && old_branch && branch_result) begin
         target_q[u_idx] <= ex_target;
         if (!u_hit)
            tag_q[u_idx] <= u_tag;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         branch_cnt <= 32'd0;
         miss_cnt   <= 32'd0;
      end else begin
         if (old_branch)
            branch_cnt <= branch_cnt + 32'd1;
         if (mispredict)
            miss_cnt <= miss_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: allocation, hysteresis, saturation,
// target mismatch, aliasing, same-cycle read/write and asynchronous reset.
module tb_branch_predictor;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        predict_taken;
   logic [31:0] predict_target;
   logic        old_branch;
   logic [31:0] old_pc;
   logic        branch_result;
   logic        old_predict;
   logic [31:0] ex_target;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [31:0] branch_cnt;
   logic [31:0] miss_cnt;

   int n_cmp;
   int n_fail;

   branch_predictor #(.ENTRIES(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .if_pc          (if_pc),
      .predict_taken  (predict_taken),
      .predict_target (predict_target),
      .old_branch     (old_branch),
      .old_pc         (old_pc),
      .branch_result  (branch_result),
      .old_predict    (old_predict),
      .ex_target      (ex_target),
      .mispredict     (mispredict),
      .redirect_pc    (redirect_pc),
      .branch_cnt     (branch_cnt),
      .miss_cnt       (miss_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic resolve(input logic [31:0] pc, input logic res, input logic pred,
                          input logic [31:0] tgt);
      old_branch    = 1'b1;
      old_pc        = pc;
      branch_result = res;
      old_predict   = pred;
      ex_target     = tgt;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      old_branch = 1'b0;
      #1;
   endtask

   task automatic query(input string tag, input logic [31:0] pc, input logic exp_t,
                        input logic [31:0] exp_tgt);
      if_pc = pc;
      #1;
      check({tag, "_taken"}, {31'd0, predict_taken}, {31'd0, exp_t});
      check({tag, "_target"}, predict_target, exp_tgt);
   endtask

   initial begin
      n_cmp = 0;
      n_fail = 0;
      rst_n = 1'b0;
      if_pc = 32'h100;
      old_branch = 1'b0;
      old_pc = 32'h0;
      branch_result = 1'b0;
      old_predict = 1'b0;
      ex_target = 32'h0;
      #2;
      query("rst_q100", 32'h100, 1'b0, 32'h104);
      check("rst_bcnt", branch_cnt, 32'd0);
      check("rst_mcnt", miss_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Allocation at 0x100; same-cycle query still sees the empty entry
      resolve(32'h100, 1'b1, 1'b0, 32'h200);
      #1;
      check("alloc_misp", {31'd0, mispredict}, 32'd1);
      check("alloc_redir", redirect_pc, 32'h200);
      query("alloc_pre", 32'h100, 1'b0, 32'h104);
      tick();
      check("alloc_misp_idle", {31'd0, mispredict}, 32'd0);
      query("alloc_post", 32'h100, 1'b1, 32'h200);
      check("alloc_bcnt", branch_cnt, 32'd1);
      check("alloc_mcnt", miss_cnt, 32'd1);

      // Hysteresis: 10 -> 01 -> 00
      resolve(32'h100, 1'b0, 1'b1, 32'h0);
      #1;
      check("nt1_misp", {31'd0, mispredict}, 32'd1);
      check("nt1_redir", redirect_pc, 32'h104);
      tick();
      query("nt1_post", 32'h100, 1'b0, 32'h104);
      resolve(32'h100, 1'b0, 1'b0, 32'h0);
      #1;
      check("nt2_misp", {31'd0, mispredict}, 32'd0);
      tick();
      query("nt2_post", 32'h100, 1'b0, 32'h104);

      // 00 -> 01 -> 10 -> 11 -> 11
      resolve(32'h100, 1'b1, 1'b0, 32'h200);
      tick();
      query("t1_post", 32'h100, 1'b0, 32'h104);
      resolve(32'h100, 1'b1, 1'b0, 32'h200);
      tick();
      query("t2_post", 32'h100, 1'b1, 32'h200);
      resolve(32'h100, 1'b1, 1'b1, 32'h200);
      #1;
      check("t3_misp", {31'd0, mispredict}, 32'd0);
      tick();
      resolve(32'h100, 1'b1, 1'b1, 32'h200);
      tick();
      // One not-taken from saturated 11 must stay predicted taken
      resolve(32'h100, 1'b0, 1'b1, 32'h0);
      tick();
      query("sat_post", 32'h100, 1'b1, 32'h200);
      check("sat_bcnt", branch_cnt, 32'd8);
      check("sat_mcnt", miss_cnt, 32'd5);

      // Taken and predicted taken but wrong stored target
      resolve(32'h100, 1'b1, 1'b1, 32'h300);
      #1;
      check("tgt_misp", {31'd0, mispredict}, 32'd1);
      check("tgt_redir", redirect_pc, 32'h300);
      tick();
      query("tgt_post", 32'h100, 1'b1, 32'h300);

      // Aliasing: 0x140 shares index 0 with 0x100
      resolve(32'h140, 1'b1, 1'b0, 32'h400);
      #1;
      check("alias_misp", {31'd0, mispredict}, 32'd1);
      tick();
      query("alias_140", 32'h140, 1'b1, 32'h400);
      query("alias_100", 32'h100, 1'b0, 32'h104);
      check("alias_bcnt", branch_cnt, 32'd10);
      check("alias_mcnt", miss_cnt, 32'd7);

      // Same-cycle read/write at 0x108: bring ctr to 01, then 01 -> 10
      resolve(32'h108, 1'b1, 1'b0, 32'h500);
      tick();
      resolve(32'h108, 1'b0, 1'b1, 32'h0);
      tick();
      query("rw_before", 32'h108, 1'b0, 32'h10c);
      resolve(32'h108, 1'b1, 1'b0, 32'h500);
      query("rw_same", 32'h108, 1'b0, 32'h10c);
      tick();
      query("rw_next", 32'h108, 1'b1, 32'h500);

      // Tag miss not-taken leaves the entry alone
      resolve(32'h180, 1'b0, 1'b0, 32'h0);
      #1;
      check("ntmiss_misp", {31'd0, mispredict}, 32'd0);
      tick();
      query("ntmiss_140", 32'h140, 1'b1, 32'h400);
      query("ntmiss_180", 32'h180, 1'b0, 32'h184);

      // Idle EX with inconsistent don't-care inputs
      old_branch = 1'b0;
      branch_result = 1'b1;
      old_predict = 1'b0;
      #1;
      check("idle_misp", {31'd0, mispredict}, 32'd0);
      tick();
      check("idle_bcnt", branch_cnt, 32'd14);
      check("idle_mcnt", miss_cnt, 32'd10);

      // Asynchronous reset between edges, with an update pending
      if_pc = 32'h140;
      resolve(32'h108, 1'b1, 1'b0, 32'h600);
      #1;
      rst_n = 1'b0;
      #1;
      check("arst_taken", {31'd0, predict_taken}, 32'd0);
      check("arst_target", predict_target, 32'h144);
      check("arst_bcnt", branch_cnt, 32'd0);
      check("arst_mcnt", miss_cnt, 32'd0);
      check("arst_misp", {31'd0, mispredict}, 32'd1);
      check("arst_redir", redirect_pc, 32'h600);
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      query("arst_108", 32'h108, 1'b0, 32'h10c);
      check("arst_bcnt2", branch_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
